// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, pointer type and depth derivation.
package fifo_pkg;

  localparam int unsigned DEF_DWIDTH    = 8;
  localparam int unsigned DEF_ADDRWIDTH = 9;

  // Wrap bit in the MSB, memory index in the low ADDRWIDTH bits.
  typedef logic [DEF_ADDRWIDTH:0] ptr_t;

  function automatic int unsigned depth_of(input int unsigned addrwidth);
    return 32'(1) << addrwidth;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DWIDTH array, synchronous write, asynchronous read, no reset.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0]    rdata
);

  localparam int unsigned DEPTH = depth_of(ADDRWIDTH);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost flags, occupancy count, sticky
// error flags and selectable first-word-fall-through read mode.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int unsigned FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic                 rinc,
  output logic [DWIDTH-1:0]    rdata,
  input  logic [ADDRWIDTH:0]   af_thresh,
  input  logic [ADDRWIDTH:0]   ae_thresh,
  input  logic                 err_clr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDRWIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned DEPTH = depth_of(ADDRWIDTH);
  localparam int unsigned CW    = ADDRWIDTH + 1;

  logic [CW-1:0]     wptr;
  logic [CW-1:0]     rptr;
  logic [CW-1:0]     count_next;
  logic              wr_acc;
  logic              rd_acc;
  logic [DWIDTH-1:0] mem_rdata;

  // Acceptance is gated by the registered flags only.
  assign wr_acc = winc && !full;
  assign rd_acc = rinc && !empty;

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  sync_fifo_mem #(
    .DWIDTH   (DWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wptr[ADDRWIDTH-1:0]),
    .wdata(wdata),
    .raddr(rptr[ADDRWIDTH-1:0]),
    .rdata(mem_rdata)
  );

  // Pointers, occupancy and flags all describe the state after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (af_thresh == '0);
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc) wptr <= wptr + CW'(1);
      if (rd_acc) rptr <= rptr + CW'(1);
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= af_thresh);
      almost_empty <= (count_next <= ae_thresh);
    end
  end

  // Sticky errors; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (rinc && empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata = mem_rdata;
  end else begin : g_std
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         rdata <= '0;
      else if (rd_acc) rdata <= mem_rdata;
    end
  end

endmodule
